// File: rtl/i2c_codec_target.sv
`timescale 1ns/1ps
// i2c_codec_target
//   Write-only I2C target for 24-bit codec configuration frames
//   {SLAVE_ADDR+W, SUB, DATA}. Each completed frame is decoded into a 7-bit
//   register address and a 9-bit value, strobed out, and mirrored into a
//   16-entry shadow register file that can be read back from logic.
// Ports
//   iCLK       system clock, at least 32x SCL
//   iRST       synchronous active-high reset
//   I2C_SCLK   I2C clock from the master (input only, never stretched)
//   I2C_SDAT   I2C data, open-drain: driven 0 or released
//   oREG_WE    one-cycle strobe for a completed frame
//   oREG_ADDR  register address of the last completed frame
//   oREG_DATA  register value of the last completed frame
//   iRD_ADDR   shadow register read index
//   oRD_DATA   shadow register contents, registered (1-cycle latency)
//   oBUSY      high from START until STOP
module i2c_codec_target #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h1A,
   parameter int unsigned FILT_LEN   = 3
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       I2C_SCLK,
   inout  logic       I2C_SDAT,
   output logic       oREG_WE,
   output logic [6:0] oREG_ADDR,
   output logic [8:0] oREG_DATA,
   input  logic [3:0] iRD_ADDR,
   output logic [8:0] oRD_DATA,
   output logic       oBUSY
);

   localparam int unsigned CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_A, SUB, ACK_S, DATA, ACK_D, IGNORE
   } state_t;

   state_t        state;
   logic [3:0]    bitCnt;
   logic [7:0]    shiftReg;
   logic [7:0]    subReg;
   logic          sdaLow;
   logic [8:0]    shadow [16];

   // Line index 0 = SCL, 1 = SDA
   logic [1:0]    sync1, sync2;
   logic [1:0]    filt, filtPrev;
   logic [CW-1:0] cnt [2];

   logic scl, sda, sclPrev, sdaPrev;
   logic sclRise, sclFall, startDet, stopDet, byteDone;
   logic frameWr, shadowWe;
   logic [3:0] shadowIdx;
   logic [8:0] newVal;

   assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

   // Synchronizer plus glitch filter: a level change is accepted only after
   // FILT_LEN consecutive synchronized samples disagree with the filtered value.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sync1    <= '1;
         sync2    <= '1;
         filt     <= '1;
         filtPrev <= '1;
         for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync1    <= {I2C_SDAT, I2C_SCLK};
         sync2    <= sync1;
         filtPrev <= filt;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
               filt[i] <= sync2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      scl      = filt[0];
      sda      = filt[1];
      sclPrev  = filtPrev[0];
      sdaPrev  = filtPrev[1];
      sclRise  = scl & ~sclPrev;
      sclFall  = ~scl & sclPrev;
      startDet = scl & sclPrev & sdaPrev & ~sda;
      stopDet  = scl & sclPrev & ~sdaPrev & sda;
      byteDone = sclFall && (bitCnt == 4'd8);
      // START/STOP need SCL high, so they never coincide with an SCL fall
      frameWr   = (state == DATA) && byteDone;
      shadowWe  = frameWr && (subReg[7:5] == 3'b000);
      shadowIdx = subReg[4:1];
      newVal    = {subReg[0], shiftReg};
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= IDLE;
         bitCnt    <= '0;
         shiftReg  <= '0;
         subReg    <= '0;
         sdaLow    <= 1'b0;
         oREG_WE   <= 1'b0;
         oREG_ADDR <= '0;
         oREG_DATA <= '0;
         oRD_DATA  <= '0;
         oBUSY     <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) shadow[i] <= '0;
      end else begin
         oREG_WE <= 1'b0;

         // Write-first: a same-cycle write to the read index is forwarded
         if (shadowWe && (shadowIdx == iRD_ADDR)) oRD_DATA <= newVal;
         else                                     oRD_DATA <= shadow[iRD_ADDR];

         if (shadowWe) shadow[shadowIdx] <= newVal;

         if (startDet) begin
            state  <= ADDR;
            bitCnt <= '0;
            sdaLow <= 1'b0;
            oBUSY  <= 1'b1;
         end else if (stopDet) begin
            state  <= IDLE;
            sdaLow <= 1'b0;
            oBUSY  <= 1'b0;
         end else begin
            case (state)
               ADDR, SUB, DATA: begin
                  if (sclRise) begin
                     shiftReg <= {shiftReg[6:0], sda};
                     bitCnt   <= bitCnt + 4'd1;
                  end else if (byteDone) begin
                     if (state == ADDR) begin
                        if (shiftReg == {SLAVE_ADDR, 1'b0}) begin
                           state  <= ACK_A;
                           sdaLow <= 1'b1;
                        end else begin
                           state  <= IGNORE;
                        end
                     end else if (state == SUB) begin
                        subReg <= shiftReg;
                        state  <= ACK_S;
                        sdaLow <= 1'b1;
                     end else begin
                        oREG_WE   <= 1'b1;
                        oREG_ADDR <= subReg[7:1];
                        oREG_DATA <= newVal;
                        state     <= ACK_D;
                        sdaLow    <= 1'b1;
                     end
                  end
               end
               // The first SCL fall seen in an ACK state is the 9th of the byte
               ACK_A, ACK_S, ACK_D: begin
                  if (sclFall) begin
                     sdaLow <= 1'b0;
                     bitCnt <= '0;
                     case (state)
                        ACK_A:   state <= SUB;
                        ACK_S:   state <= DATA;
                        default: state <= IGNORE;
                     endcase
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_codec_target.sv
`timescale 1ns/1ps
// Directed bench for i2c_codec_target: an I2C master model drives frames
// with hand-computed expected decodes, shadow contents and ACK/NACK bits.
module tb_i2c_codec_target;

   localparam int Q = 100;  // quarter SCL period (40 iCLK per SCL bit)

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       mLow;
   logic [3:0] rdAddr;
   wire        sda;
   logic       regWe;
   logic [6:0] regAddr;
   logic [8:0] regData;
   logic [8:0] rdData;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int weCount  = 0;
   int sdaDrv   = 0;

   always #5 clk = ~clk;

   assign sda = mLow ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_codec_target #(.SLAVE_ADDR(7'h1A), .FILT_LEN(3)) dut (
      .iCLK     (clk),
      .iRST     (rst),
      .I2C_SCLK (scl),
      .I2C_SDAT (sda),
      .oREG_WE  (regWe),
      .oREG_ADDR(regAddr),
      .oREG_DATA(regData),
      .iRD_ADDR (rdAddr),
      .oRD_DATA (rdData),
      .oBUSY    (busy)
   );

   // Strobe cycles and cycles where the target pulls SDA low
   always @(negedge clk) begin
      if (regWe === 1'b1) weCount++;
      if (!mLow && sda === 1'b0) sdaDrv++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic startCond();
      mLow = 1'b0; #Q; scl = 1'b1; #Q; mLow = 1'b1; #Q; scl = 1'b0; #Q;
   endtask

   task automatic stopCond();
      mLow = 1'b1; #Q; scl = 1'b1; #Q; mLow = 1'b0; #Q;
   endtask

   task automatic sendBit(input logic b, input logic glitch);
      mLow = ~b;
      if (glitch) begin
         #40; scl = 1'b1; #10; scl = 1'b0; #50;
      end else begin
         #Q;
      end
      scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
   endtask

   task automatic writeByte(input logic [7:0] b, input int glitchBit, output logic ack);
      for (int i = 7; i >= 0; i--) sendBit(b[i], i == glitchBit);
      mLow = 1'b0; #Q; scl = 1'b1; #Q; ack = sda; #Q; scl = 1'b0; #Q;
   endtask

   task automatic readShadow(input logic [3:0] idx, output logic [8:0] v);
      @(negedge clk); rdAddr = idx;
      @(negedge clk); v = rdData;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a0, a1, a2, a3;
      logic [8:0] v;
      int we0, drv0;

      rst = 1'b1; scl = 1'b1; mLow = 1'b0; rdAddr = 4'd0;
      #100; rst = 1'b0; #200;

      // Reset state
      chk("rstWe",   32'(regWe),   0);
      chk("rstAddr", 32'(regAddr), 0);
      chk("rstData", 32'(regData), 0);
      chk("rstRd",   32'(rdData),  0);
      chk("rstBusy", 32'(busy),    0);
      chk("rstSda",  32'(sda),     1);

      // 0x34,0x1E,0x00 -> addr 0x0F, data 0x000
      we0 = weCount; drv0 = sdaDrv;
      startCond();
      writeByte(8'h34, -1, a0); writeByte(8'h1E, -1, a1); writeByte(8'h00, -1, a2);
      chk("A_busyIn", 32'(busy), 1);
      stopCond(); #Q;
      chk("A_acks",   32'({a0, a1, a2}), 0);
      chk("A_drove",  32'(sdaDrv > drv0), 1);
      chk("A_strobe", 32'(weCount - we0), 1);
      chk("A_addr",   32'(regAddr), 'h0F);
      chk("A_data",   32'(regData), 'h000);
      chk("A_busy",   32'(busy), 0);
      readShadow(4'd15, v);
      chk("A_sh15",   32'(v), 'h000);

      // 0x34,0x05,0xFF -> addr 0x02, data 0x1FF
      we0 = weCount;
      startCond();
      writeByte(8'h34, -1, a0); writeByte(8'h05, -1, a1); writeByte(8'hFF, -1, a2);
      stopCond(); #Q;
      chk("B_acks",   32'({a0, a1, a2}), 0);
      chk("B_strobe", 32'(weCount - we0), 1);
      chk("B_addr",   32'(regAddr), 'h02);
      chk("B_data",   32'(regData), 'h1FF);
      readShadow(4'd2, v);
      chk("B_sh2",    32'(v), 'h1FF);

      // Wrong address 0x36 -> all NACK, SDA never driven, no strobe
      we0 = weCount; drv0 = sdaDrv;
      startCond();
      writeByte(8'h36, -1, a0); writeByte(8'h08, -1, a1); writeByte(8'hF8, -1, a2);
      stopCond(); #Q;
      chk("C_acks",   32'({a0, a1, a2}), 'b111);
      chk("C_drove",  32'(sdaDrv - drv0), 0);
      chk("C_strobe", 32'(weCount - we0), 0);
      chk("C_addrHold", 32'(regAddr), 'h02);
      chk("C_dataHold", 32'(regData), 'h1FF);
      readShadow(4'd4, v);
      chk("C_sh4",    32'(v), 'h000);

      // Read request 0x35 -> NACK, busy until STOP
      we0 = weCount;
      startCond();
      writeByte(8'h35, -1, a0);
      chk("D_nack",   32'(a0), 1);
      chk("D_busy1",  32'(busy), 1);
      stopCond(); #Q;
      chk("D_busy0",  32'(busy), 0);
      chk("D_strobe", 32'(weCount - we0), 0);

      // Repeated START abandons first frame
      we0 = weCount;
      startCond();
      writeByte(8'h34, -1, a0); writeByte(8'h12, -1, a1);
      startCond();
      writeByte(8'h34, -1, a2); writeByte(8'h12, -1, a3); writeByte(8'h01, -1, a0);
      stopCond(); #Q;
      chk("E_acks",   32'({a0, a1, a2, a3}), 0);
      chk("E_strobe", 32'(weCount - we0), 1);
      chk("E_addr",   32'(regAddr), 'h09);
      chk("E_data",   32'(regData), 'h001);
      readShadow(4'd9, v);
      chk("E_sh9",    32'(v), 'h001);

      // SUB 0x40 (addr 0x20 > 15) plus an extra byte
      we0 = weCount;
      startCond();
      writeByte(8'h34, -1, a0); writeByte(8'h40, -1, a1);
      writeByte(8'h11, -1, a2); writeByte(8'h22, -1, a3);
      stopCond(); #Q;
      chk("F_acks",   32'({a0, a1, a2, a3}), 'b0001);
      chk("F_strobe", 32'(weCount - we0), 1);
      chk("F_addr",   32'(regAddr), 'h20);
      chk("F_data",   32'(regData), 'h011);
      readShadow(4'd0, v);
      chk("F_sh0",    32'(v), 'h000);

      // Reset during DATA byte
      we0 = weCount;
      startCond();
      writeByte(8'h34, -1, a0); writeByte(8'h08, -1, a1);
      for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
      mLow = 1'b0;
      @(negedge clk); rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("G_sda",    32'(sda), 1);
      chk("G_busy",   32'(busy), 0);
      chk("G_addr",   32'(regAddr), 0);
      chk("G_data",   32'(regData), 0);
      chk("G_strobe", 32'(weCount - we0), 0);
      readShadow(4'd2, v);
      chk("G_sh2",    32'(v), 'h000);
      #Q;
      startCond();
      writeByte(8'h34, -1, a0); writeByte(8'h08, -1, a1); writeByte(8'hF8, -1, a2);
      stopCond(); #Q;
      chk("G_acks",   32'({a0, a1, a2}), 0);
      chk("G_strobe2", 32'(weCount - we0), 1);
      chk("G_addr2",  32'(regAddr), 'h04);
      chk("G_data2",  32'(regData), 'h0F8);
      readShadow(4'd4, v);
      chk("G_sh4",    32'(v), 'h0F8);

      // 1-iCLK SCL glitch inside the SUB byte
      we0 = weCount;
      startCond();
      writeByte(8'h34, -1, a0); writeByte(8'h0C, 3, a1); writeByte(8'h5A, -1, a2);
      stopCond(); #Q;
      chk("H_acks",   32'({a0, a1, a2}), 0);
      chk("H_strobe", 32'(weCount - we0), 1);
      chk("H_addr",   32'(regAddr), 'h06);
      chk("H_data",   32'(regData), 'h05A);
      readShadow(4'd6, v);
      chk("H_sh6",    32'(v), 'h05A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
